output_argmax_collector: RTL
============================

// Module: output_argmax_collector
// PURPOSE
//  Consumer end of the output-layer score interface. Accepts one signed 8-bit score
//  per output neuron, serially, over a valid/ready stream, and tracks the running maximum.
//  At the end of a frame it presents the winning class index and score on a result handshake.
//  Sits after the output-layer neurons and feeds the classification result to the host/control logic.
// PARAMETERS
//  NUM_CLASSES  10                         number of output neurons (scores) per frame, >=2
//  DATA_W       8                          score width, two's-complement signed
//  IDX_W        $clog2(NUM_CLASSES+1)      class index width; holds the reject code NUM_CLASSES
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  s_valid    in   1       score beat valid
//  s_ready    out  1       collector can accept a beat
//  s_score    in   DATA_W  signed score of current neuron
//  s_last     in   1       final score of the frame
//  res_valid  out  1       result valid
//  res_ready  in   1       downstream accepts result
//  res_class  out  IDX_W   winning class index (0-based arrival order)
//  res_score  out  DATA_W  winning (maximum) score
//  res_err    out  1       frame-length error flag for this result
//  min_score  in   DATA_W  confidence floor (present only with ARGMAX_MIN_CONF_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, count=0, s_ready=1, res_valid=0, res_class=0, res_score=0, res_err=0.
//  - Beat transfer when s_valid&&s_ready; outputs change only on clk rising edge.
//  - FSM: IDLE -(beat)-> COLLECT, or -> DONE if the beat ends the frame; COLLECT -(frame-ending beat)-> DONE;
//    DONE -(res_valid&&res_ready)-> IDLE.
//  - s_ready=1 in IDLE/COLLECT, 0 in DONE (no buffering; backpressure until result is taken).
//  - First beat of frame loads max=s_score, idx=0. Later beats: update iff s_score > max (signed, strict);
//    ties keep the lower index.
//  - Frame ends on the first beat with s_last=1 OR count==NUM_CLASSES-1, whichever comes first.
//    res_err=1 if the two disagree (early s_last, or s_last missing at the final beat); otherwise 0.
//  - Latency: res_valid rises the cycle after the frame-ending beat is accepted; res_* remain stable
//    while res_valid&&!res_ready.
//  - IDLE->COLLECT->DONE with res_ready held at 1: result takes one cycle, next frame accepted the cycle after.
//  - count wraps to 0 at the start of each frame; it never exceeds NUM_CLASSES-1.
//  - NUM_CLASSES==1 is unsupported (checked by an elaboration assertion).
//  - Reset mid-frame discards partial frame and any pending result; no res_valid is produced for it.
// CONFIGURATION
//  ARGMAX_MIN_CONF_EN defined: min_score port exists; at frame end, if max < min_score (signed),
//    res_class=NUM_CLASSES (reject code) and res_score=max; res_err unaffected.
//  ARGMAX_MIN_CONF_EN undefined: no min_score port; res_class is always in 0..NUM_CLASSES-1.
// STRUCTURE
//  - nn_pkg: DATA_W, NUM_CLASSES defaults; argmax_state_t enum {IDLE, COLLECT, DONE}; REJECT_IDX constant.
//  - Sub-module argmax_compare: combinational signed compare of (score,idx) vs (max,idx) -> update flag.
//    The top level holds the FSM, counter and registers.
// TESTING
//  - Scores 3,-5,12,7,0,1,2,9,11,4 with s_last on beat 9 -> res_class=2, res_score=12, res_err=0.
//  - All ten scores = -128 -> res_class=0, res_score=-128 (tie keeps lowest index).
//  - s_last on beat 4 with scores 1,2,3,4,5 -> frame closes, res_class=4, res_score=5, res_err=1.
//  - res_ready held 0 for 5 cycles after a frame -> s_ready=0 and res_* stable; next frame accepted only after handshake.
//  - Assert rst_n=0 after 6 beats -> all outputs at reset values; fresh 10-beat frame with winner 9 -> res_class=9.
//  - ARGMAX_MIN_CONF_EN with min_score=20 and max score 12 -> res_class=10 (reject), res_score=12.

Source files
------------

// File: rtl/nn_pkg.sv
// nn_pkg: shared defaults and state type for the output-layer argmax collector
// Exports the default score width, default class count, the collector state
// encoding and the reject class code.
package nn_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int REJECT_IDX = DEF_NUM_CLASSES;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} argmax_state_t;
endpackage

// File: rtl/argmax_compare.sv
// argmax_compare: decides whether an incoming (score, idx) displaces the held (max, max_idx)
// Ports: first - first beat of frame, always loads
//        score/idx - incoming signed score and its arrival index
//        max/max_idx - currently held winner
//        update - take the incoming beat as the new winner
module argmax_compare import nn_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W = 4
) (
  input  logic                     first,
  input  logic signed [DATA_W-1:0] score,
  input  logic        [IDX_W-1:0]  idx,
  input  logic signed [DATA_W-1:0] max,
  input  logic        [IDX_W-1:0]  max_idx,
  output logic                     update
);
  // Strictly greater wins; on a tie the lower index is kept.
  assign update = first || (score > max) || (score == max && idx < max_idx);
endmodule

// File: rtl/output_argmax_collector.sv
// output_argmax_collector: serial argmax over one frame of signed output-layer scores
// Ports: clk, rst_n (async, active low)
//        s_valid/s_ready/s_score/s_last - score stream, one beat per output neuron
//        res_valid/res_ready - result handshake
//        res_class/res_score/res_err - winning index, winning score, frame-length error
//        min_score - confidence floor, present only when ARGMAX_MIN_CONF_EN is defined
module output_argmax_collector import nn_pkg::*; #(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W = $clog2(NUM_CLASSES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_score,
  input  logic                     s_last,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic        [IDX_W-1:0]  res_class,
  output logic signed [DATA_W-1:0] res_score,
  output logic                     res_err
`ifdef ARGMAX_MIN_CONF_EN
  ,
  input  logic signed [DATA_W-1:0] min_score
`endif
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  if (NUM_CLASSES < 2) begin : g_bad_cfg
    $error("output_argmax_collector: NUM_CLASSES must be >= 2");
  end
  argmax_state_t state;
  logic [IDX_W-1:0] count, idx_q, nxt_idx, win_idx;
  logic signed [DATA_W-1:0] max_q, nxt_max;
  logic beat, at_last, frame_end, update;
  assign s_ready = state != DONE;
  assign beat = s_valid && s_ready;
  assign at_last = count == LAST_IDX;
  // A frame closes on whichever comes first: s_last or the final expected beat.
  assign frame_end = s_last || at_last;
  argmax_compare #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
    .first(state == IDLE),
    .score(s_score),
    .idx(count),
    .max(max_q),
    .max_idx(idx_q),
    .update(update)
  );
  assign nxt_max = update ? s_score : max_q;
  assign nxt_idx = update ? count : idx_q;
`ifdef ARGMAX_MIN_CONF_EN
  assign win_idx = (nxt_max < min_score) ? IDX_W'(NUM_CLASSES) : nxt_idx;
`else
  assign win_idx = nxt_idx;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      max_q <= '0;
      idx_q <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
      res_score <= '0;
      res_err <= 1'b0;
    end else if (beat) begin
      max_q <= nxt_max;
      idx_q <= nxt_idx;
      count <= frame_end ? '0 : count + IDX_W'(1);
      state <= frame_end ? DONE : COLLECT;
      if (frame_end) begin
        res_valid <= 1'b1;
        res_class <= win_idx;
        res_score <= nxt_max;
        res_err <= s_last ^ at_last;
      end
    end else if (res_valid && res_ready) begin
      state <= IDLE;
      res_valid <= 1'b0;
    end
  end
endmodule
